console_out_ctrl: RTL and testbench
===================================

Name: console_out_ctrl

Overview:
- Sequences the CPU's character-output port (`interrupt` strobe + 8-bit `value`) onto a physical 8N1 serial line.
- Buffers characters in a FIFO and applies backpressure to the CPU when the FIFO is full.
- Treats `value == 0` as end-of-stream and raises `done` once every buffered character has been transmitted.
- Sits between MIPS_CPU and the board pin; in simulation the bench decodes `tx` instead of sampling `value` directly.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 4, clock cycles per serial bit; minimum 1.
- DATA_W, 8, character width; fixed at 8 for 8N1 framing.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- interrupt  in  1  CPU output strobe; one push per high cycle.
- value  in  DATA_W  character qualified by `interrupt`.
- stall  out  1  FIFO full; CPU must hold the strobe.
- tx  out  1  serial line, idle high.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- done  out  1  end-of-stream seen and fully drained; sticky.
- overflow  out  1  strobe dropped while full; sticky.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: asserts asynchronously; leaves reset on the first clk edge after rst_n rises. During reset all of the following hold:
  - tx=1; stall=0, busy=0, done=0, overflow=0, count=0
  - FSM in IDLE; FIFO pointers 0; eos_seen=0
- Reset mid-frame aborts the frame immediately (tx=1) and discards FIFO contents.
- Accept rule, evaluated on each edge with interrupt=1:
  - eos_seen=1: strobe ignored (no push, no overflow).
  - value==0: sets eos_seen; nothing is pushed.
  - Otherwise, not full (or full with a pop on the same edge): push; count updates next cycle.
  - Otherwise, full with no pop: drop the character and set overflow.
- stall = (count==DEPTH), decoded from registered count; no combinational path from interrupt.
- Simultaneous push and pop: both happen and count is unchanged; this holds at full as well.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH; occupancy is tracked by `count`, not derived from the pointers.
- TX FSM states: IDLE, START, DATA, STOP.
  - Bit timer counts CLKS_PER_BIT-1 down to 0; the state advances when the timer is 0.
  - Bit index runs 0..7.
- IDLE: tx=1. If count!=0, pop the head into the shift register and go to START on that edge.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0], LSB first. Shift after each bit; after bit 7 go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the final STOP cycle:
  - count!=0: pop and go directly to START (no idle gap).
  - else: go to IDLE.
- Latency:
  - Strobe captured at edge N; count=1 after N.
  - FSM pops at edge N+1; tx falls after N+1.
  - Each frame is exactly 10*CLKS_PER_BIT cycles.
- done: set on the edge where eos_seen=1, count==0 and state==IDLE. Cleared only by reset.
- busy = (state!=IDLE) || (count!=0).

Decomposition:
- Shared package console_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, STOP);
  - localparam EOS_CHAR = 8'h00;
  - localparam FRAME_BITS = 10.
- Natural sub-module: sync_fifo (parameters DEPTH, DATA_W).
  - Inputs: push, pop, din. Outputs: dout (head, combinational), full, empty, count.
  - The controller owns the FSM, the eos/done/overflow flags and the drop rule.

Test Plan:
- Single char: after reset, strobe value=8'h41 for one cycle (CLKS_PER_BIT=4) -> tx low 4 cycles starting 1 cycle after capture; bits 1,0,0,0,0,0,1,0; stop high; 40-cycle frame; busy falls after stop; done=0.
- String + EOS: strobe "Hi" then 8'h00 on consecutive cycles -> two back-to-back frames with no idle gap; done rises exactly 1 edge after the second stop bit ends; bench-decoded output is "Hi".
- Full/backpressure (DEPTH=4): 6 strobes on consecutive cycles -> 1 popped + 4 queued.
  - stall=1 once count==4.
  - 6th strobe dropped; overflow=1 and stays 1.
  - count never exceeds 4.
- Push+pop at full: hold count==DEPTH and strobe on the final STOP cycle of the current frame -> character accepted, count unchanged, overflow stays 0.
- Post-EOS strobes: after 8'h00, strobe 8'h42 -> no push, no frame, overflow unchanged, done still asserts.
- Reset mid-frame: drop rst_n during DATA bit 3 -> tx=1 and outputs at reset values immediately; a new 8'h55 after release transmits cleanly with the correct framing.

Source files
------------

// File: rtl/console_pkg.sv
// Shared types and constants for the console serial output path.
package console_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [7:0] EOS_CHAR   = 8'h00;
  localparam int         FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output and explicit occupancy count.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              w_do_pop;
  logic              w_do_push;

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  assign dout  = r_mem[r_rptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/console_out_ctrl.sv
// Buffers CPU console characters and serialises them as 8N1 frames on tx.
module console_out_ctrl
  import console_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   interrupt,
  input  logic [DATA_W-1:0]      value,
  output logic                   stall,
  output logic                   tx,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);
  localparam int              CW       = $clog2(DEPTH) + 1;
  localparam int              TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      IDX_LAST = 3'(DATA_W - 1);

  tx_state_t         r_state, w_state_nxt;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_eos_seen, r_done, r_overflow;
  logic              w_pop, w_push, w_drop, w_accept, w_eos;
  logic              w_full, w_empty;
  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_count;

  // Once end-of-stream is seen every later strobe is ignored outright.
  assign w_eos    = interrupt && !r_eos_seen && (value == DATA_W'(EOS_CHAR));
  assign w_accept = interrupt && !r_eos_seen && (value != DATA_W'(EOS_CHAR));
  assign w_push   = w_accept && (!w_full || w_pop);
  assign w_drop   = w_accept && w_full && !w_pop;

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (value),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    tx          = 1'b1;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_timer_nxt = BIT_LAST;
          w_state_nxt = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (r_timer == '0) begin
          w_state_nxt = DATA;
          w_timer_nxt = BIT_LAST;
          w_bit_nxt   = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      DATA: begin
        tx = r_shift[0];
        if (r_timer == '0) begin
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          w_timer_nxt = BIT_LAST;
          if (r_bit == IDX_LAST) w_state_nxt = STOP;
          else                   w_bit_nxt   = r_bit + 1'b1;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (r_timer == '0) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_timer_nxt = BIT_LAST;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_bit      <= '0;
      r_eos_seen <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_bit   <= w_bit_nxt;
      if (w_eos)  r_eos_seen <= 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      if (r_eos_seen && w_empty && (r_state == IDLE)) r_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  assign stall    = w_full;
  assign busy     = (r_state != IDLE) || !w_empty;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign count    = w_count;

endmodule

// File: tb/tb_console_out_ctrl.sv
// Directed bench for console_out_ctrl with DEPTH=4, CLKS_PER_BIT=4.
module tb_console_out_ctrl;
  import console_pkg::*;

  localparam int DEPTH     = 4;
  localparam int CPB       = 4;
  localparam int DATA_W    = 8;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          interrupt = 1'b0;
  logic [7:0]    value     = 8'h00;
  logic          stall, tx, busy, done, overflow;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  console_out_ctrl #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .interrupt (interrupt),
    .value     (value),
    .stall     (stall),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .count     (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx"},       32'(tx),       32'd1);
    chk({tag, "_stall"},    32'(stall),    32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_count"},    32'(count),    32'd0);
  endtask

  // Called at cycle k0 of a frame (k=0 is the cycle right after the pop edge).
  task automatic check_frame(input logic [7:0] ch, input int k0, output logic [7:0] rx);
    logic [9:0] fb;
    fb = {1'b1, ch, 1'b0};
    rx = 8'h00;
    for (int k = k0; k < FRAME_CYC; k++) begin
      chk($sformatf("frame_%02h_k%0d", ch, k), 32'(tx), 32'(fb[k/CPB]));
      if ((k % CPB) == (CPB / 2) && (k / CPB) >= 1 && (k / CPB) <= 8)
        rx[k/CPB-1] = tx;
      tick();
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_reset(tag);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int         exp_cnt [6];
  int         exp_stl [6];
  int         exp_ovf [6];
  logic [7:0] rx;

  initial begin
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    exp_stl = '{0, 0, 0, 0, 1, 1};
    exp_ovf = '{0, 0, 0, 0, 0, 1};

    #2;
    chk_reset("rst_async");
    tick();
    tick();
    chk_reset("rst_hold");
    rst_n = 1'b1;
    tick();
    chk_reset("rst_release");

    // Single character
    interrupt = 1'b1; value = 8'h41;
    tick();
    interrupt = 1'b0;
    chk("t1_count_after_capture", 32'(count), 32'd1);
    chk("t1_tx_before_pop",       32'(tx),    32'd1);
    chk("t1_busy_queued",         32'(busy),  32'd1);
    tick();
    chk("t1_count_after_pop",     32'(count), 32'd0);
    check_frame(8'h41, 0, rx);
    chk("t1_decoded",             32'(rx),    32'h41);
    chk("t1_busy_after_stop",     32'(busy),  32'd0);
    chk("t1_tx_idle",             32'(tx),    32'd1);
    chk("t1_done",                32'(done),  32'd0);

    // "Hi" followed by end-of-stream
    interrupt = 1'b1; value = 8'h48;
    tick();
    value = 8'h69;
    tick();
    value = 8'h00;
    tick();
    interrupt = 1'b0;
    chk("t2_count_queued", 32'(count), 32'd1);
    check_frame(8'h48, 1, rx);
    chk("t2_decoded_H", 32'(rx), 32'h48);
    check_frame(8'h69, 0, rx);
    chk("t2_decoded_i", 32'(rx), 32'h69);
    chk("t2_done_not_yet", 32'(done), 32'd0);
    chk("t2_busy_idle",    32'(busy), 32'd0);
    tick();
    chk("t2_done_set",     32'(done), 32'd1);

    // Strobe after end-of-stream is ignored
    interrupt = 1'b1; value = 8'h42;
    tick();
    interrupt = 1'b0;
    chk("t3_count",    32'(count),    32'd0);
    chk("t3_busy",     32'(busy),     32'd0);
    chk("t3_overflow", 32'(overflow), 32'd0);
    tick();
    chk("t3_tx",       32'(tx),       32'd1);
    chk("t3_done",     32'(done),     32'd1);

    do_reset("rst_after_eos");

    // Six consecutive strobes into a four-entry FIFO
    for (int i = 0; i < 6; i++) begin
      interrupt = 1'b1; value = 8'(8'h41 + i);
      tick();
      chk($sformatf("t4_count_%0d", i),    32'(count),    32'(exp_cnt[i]));
      chk($sformatf("t4_stall_%0d", i),    32'(stall),    32'(exp_stl[i]));
      chk($sformatf("t4_overflow_%0d", i), 32'(overflow), 32'(exp_ovf[i]));
    end
    interrupt = 1'b0;
    tick();
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);
    chk("t4_count_capped",    32'(count),    32'd4);

    do_reset("rst_after_full");

    // Push and pop on the same edge while full
    for (int i = 0; i < 5; i++) begin
      interrupt = 1'b1; value = 8'(8'h41 + i);
      tick();
    end
    interrupt = 1'b0;
    chk("t5_full_count", 32'(count), 32'd4);
    chk("t5_full_stall", 32'(stall), 32'd1);
    repeat (36) tick();
    chk("t5_last_stop_tx",    32'(tx),    32'd1);
    chk("t5_last_stop_count", 32'(count), 32'd4);
    interrupt = 1'b1; value = 8'h47;
    tick();
    interrupt = 1'b0;
    chk("t5_pp_count",    32'(count),    32'd4);
    chk("t5_pp_overflow", 32'(overflow), 32'd0);
    chk("t5_pp_next_start", 32'(tx),     32'd0);
    interrupt = 1'b1; value = 8'h48;
    tick();
    interrupt = 1'b0;
    chk("t5_drop_overflow", 32'(overflow), 32'd1);
    chk("t5_drop_count",    32'(count),    32'd4);

    do_reset("rst_after_pp");

    // Reset in the middle of a frame
    interrupt = 1'b1; value = 8'h55;
    tick();
    interrupt = 1'b0;
    tick();
    repeat (17) tick();
    chk("t6_bit3_tx",   32'(tx),   32'd0);
    chk("t6_bit3_busy", 32'(busy), 32'd1);
    do_reset("rst_mid_frame");
    interrupt = 1'b1; value = 8'h55;
    tick();
    interrupt = 1'b0;
    tick();
    check_frame(8'h55, 0, rx);
    chk("t6_decoded",  32'(rx),   32'h55);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
